// File: rtl/adder_bist_driver_if.sv
// Operand/result bus between the BIST driver and the adder under test.
interface adder_bist_driver_if;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_cin;
  logic [7:0] dut_sum;
  logic       dut_cout;

  modport master (output op_a, op_b, op_cin, input dut_sum, dut_cout);
  modport slave  (input op_a, op_b, op_cin, output dut_sum, dut_cout);
endinterface

// File: rtl/adder_bist_driver.sv
// On-chip stimulus generator and response checker for the 8-bit adder:
// two directed vectors, then LFSR vectors, with a saturating mismatch count.
module adder_bist_driver #(
  parameter int          NUM_VECTORS = 256,
  parameter int          DUT_LAT     = 0,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  adder_bist_driver_if.master        adder,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [7:0]                 err_count,
  output logic [7:0]                 first_fail_idx
);
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  LAST_IDX  = 8'(NUM_VECTORS - 1);
  localparam logic [2:0]  LAST_HOLD = 3'(DUT_LAT);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg;
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic [7:0]  vec_idx_reg;
  logic [7:0]  vec_idx_next;
  logic [2:0]  hold_reg;
  logic [7:0]  op_a_reg;
  logic [7:0]  op_b_reg;
  logic        op_cin_reg;
  logic [7:0]  op_a_next;
  logic [7:0]  op_b_next;
  logic        op_cin_next;
  logic [8:0]  exp_sum;
  logic        mismatch;
  logic [7:0]  err_inc;

  assign adder.op_a   = op_a_reg;
  assign adder.op_b   = op_b_reg;
  assign adder.op_cin = op_cin_reg;

  // Galois step: shift right, fold the mask in when a 1 falls out.
  assign lfsr_next    = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_MASK) : (lfsr_reg >> 1);
  assign vec_idx_next = vec_idx_reg + 8'd1;
  assign exp_sum      = {1'b0, op_a_reg} + {1'b0, op_b_reg} + {8'd0, op_cin_reg};
  assign mismatch     = ({adder.dut_cout, adder.dut_sum} != exp_sum);
  assign err_inc      = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

  always_comb begin
    op_a_next   = lfsr_next[7:0];
    op_b_next   = lfsr_next[15:8];
    op_cin_next = lfsr_next[0] ^ lfsr_next[8];
    if (vec_idx_next == 8'd1) begin
      op_a_next   = 8'hFF;
      op_b_next   = 8'hFF;
      op_cin_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      lfsr_reg       <= SEED_EFF;
      vec_idx_reg    <= 8'd0;
      hold_reg       <= 3'd0;
      op_a_reg       <= 8'd0;
      op_b_reg       <= 8'd0;
      op_cin_reg     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 8'd0;
      first_fail_idx <= 8'd0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg      <= RUN;
            lfsr_reg       <= SEED_EFF;
            vec_idx_reg    <= 8'd0;
            hold_reg       <= 3'd0;
            op_a_reg       <= 8'hFF;
            op_b_reg       <= 8'h01;
            op_cin_reg     <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 8'd0;
            first_fail_idx <= 8'd0;
          end
        end
        RUN: begin
          if (hold_reg != LAST_HOLD) begin
            hold_reg <= hold_reg + 3'd1;
          end else begin
            hold_reg <= 3'd0;
            if (mismatch) begin
              err_count <= err_inc;
              if (err_count == 8'd0)
                first_fail_idx <= vec_idx_reg;
            end
            if (vec_idx_reg == LAST_IDX) begin
              state_reg  <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= (err_count == 8'd0) && !mismatch;
              op_a_reg   <= 8'd0;
              op_b_reg   <= 8'd0;
              op_cin_reg <= 1'b0;
            end else begin
              vec_idx_reg <= vec_idx_next;
              op_a_reg    <= op_a_next;
              op_b_reg    <= op_b_next;
              op_cin_reg  <= op_cin_next;
              // The LFSR only advances from vector 2 onward; vector 1 is directed.
              if (vec_idx_next != 8'd1)
                lfsr_reg <= lfsr_next;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_bist_driver.sv
// Bench for adder_bist_driver: a combinational and a 2-cycle pipelined adder
// model with selectable faults, checked against a vector/result reference.
module tb_adder_bist_driver;
  localparam int NV0  = 256;
  localparam int NV1  = 256;
  localparam int LAT0 = 0;
  localparam int LAT1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_s [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic        pass_w  [2];
  logic [7:0]  err_w   [2];
  logic [7:0]  ffi_w   [2];
  logic [16:0] ops_w   [2];
  int          fault_mode [2];
  logic [7:0]  fault_key  [2];
  logic [16:0] vec_tab [2][256];
  logic [16:0] pipe1, pipe2;

  int checks = 0;
  int errors = 0;

  adder_bist_driver_if bus0 ();
  adder_bist_driver_if bus1 ();

  adder_bist_driver #(.NUM_VECTORS(NV0), .DUT_LAT(LAT0), .SEED(16'hACE1)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .adder(bus0),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .first_fail_idx(ffi_w[0])
  );

  adder_bist_driver #(.NUM_VECTORS(NV1), .DUT_LAT(LAT1), .SEED(16'h0000)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .adder(bus1),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .first_fail_idx(ffi_w[1])
  );

  // Adder under test: true sum with an optional planted fault.
  function automatic logic [8:0] adder_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic c, input int mode, input logic [7:0] key);
    logic [8:0] r;
    r = {1'b0, a} + {1'b0, b} + {8'd0, c};
    case (mode)
      1: r[3] = 1'b0;
      2: r[8] = ~r[8];
      3: if (((a ^ key) & 8'h07) == 8'h00) r[0] = ~r[0];
      default: ;
    endcase
    return r;
  endfunction

  assign ops_w[0] = {bus0.op_a, bus0.op_b, bus0.op_cin};
  assign ops_w[1] = {bus1.op_a, bus1.op_b, bus1.op_cin};
  assign {bus0.dut_cout, bus0.dut_sum} =
    adder_model(bus0.op_a, bus0.op_b, bus0.op_cin, fault_mode[0], fault_key[0]);

  always @(posedge clk) begin
    pipe1 <= ops_w[1];
    pipe2 <= pipe1;
  end
  assign {bus1.dut_cout, bus1.dut_sum} =
    adder_model(pipe2[16:9], pipe2[8:1], pipe2[0], fault_mode[1], fault_key[1]);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_vectors(input int inst, input logic [15:0] seed);
    logic [15:0] l;
    logic        lsb;
    l = (seed == 16'h0000) ? 16'h0001 : seed;
    vec_tab[inst][0] = {8'hFF, 8'h01, 1'b0};
    vec_tab[inst][1] = {8'hFF, 8'hFF, 1'b1};
    for (int n = 2; n < 256; n++) begin
      lsb = l[0];
      l = l >> 1;
      if (lsb) l = l ^ 16'hB400;
      vec_tab[inst][n] = {l[7:0], l[15:8], l[0] ^ l[8]};
    end
  endtask

  task automatic check_idle_zero(input int inst, input string tag);
    chk(tag, {busy_w[inst], done_w[inst], pass_w[inst], err_w[inst], ffi_w[inst], ops_w[inst]}, 64'd0);
  endtask

  task automatic run_check(input int inst, input int mode, input logic [7:0] key,
                           input bit hold, input int abort_at);
    int nv, lat, exp_err, exp_ffi;
    logic [16:0] v;
    logic [8:0]  r, ref_sum;
    nv  = (inst == 0) ? NV0 : NV1;
    lat = (inst == 0) ? LAT0 : LAT1;
    fault_mode[inst] = mode;
    fault_key[inst]  = key;
    exp_err = 0;
    exp_ffi = 0;
    for (int n = 0; n < nv; n++) begin
      v = vec_tab[inst][n];
      ref_sum = {1'b0, v[16:9]} + {1'b0, v[8:1]} + {8'd0, v[0]};
      r = adder_model(v[16:9], v[8:1], v[0], mode, key);
      if (r != ref_sum) begin
        if (exp_err == 0) exp_ffi = n;
        if (exp_err < 255) exp_err++;
      end
    end
    start_s[inst] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_s[inst] = 1'b0;
    for (int n = 0; n < nv; n++) begin
      for (int c = 0; c <= lat; c++) begin
        if (n == abort_at && c == 0) begin
          #1 rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
          @(negedge clk);
          check_idle_zero(inst, "abort_reset");
          $display("run inst=%0d mode=%0d key=%02h aborted at vector %0d", inst, mode, key, n);
          return;
        end
        @(negedge clk);
        chk("run_ops", {busy_w[inst], done_w[inst], ops_w[inst]}, {2'b10, vec_tab[inst][n]});
        @(posedge clk);
      end
    end
    @(negedge clk);
    chk("done_flags", {busy_w[inst], done_w[inst], pass_w[inst], ops_w[inst]},
        {1'b0, 1'b1, (exp_err == 0), 17'd0});
    chk("err_count", err_w[inst], exp_err);
    if (exp_err != 0) chk("first_fail_idx", ffi_w[inst], exp_ffi);
    $display("run inst=%0d mode=%0d key=%02h err_count=%0d first_fail_idx=%0d pass=%0b",
             inst, mode, key, err_w[inst], ffi_w[inst], pass_w[inst]);
  endtask

  initial begin
    logic [7:0] key;
    rst = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    fault_mode[0] = 0;
    fault_mode[1] = 0;
    fault_key[0] = 8'd0;
    fault_key[1] = 8'd0;
    build_vectors(0, 16'hACE1);
    build_vectors(1, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero(0, "reset_state0");
    check_idle_zero(1, "reset_state1");

    run_check(0, 0, 8'h00, 1'b0, -1);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    run_check(0, 1, 8'h00, 1'b0, -1);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    run_check(0, 2, 8'h00, 1'b0, -1);
    key = 8'($urandom_range(0, 255));
    run_check(0, 3, key, 1'b0, -1);

    run_check(1, 0, 8'h00, 1'b0, -1);
    key = 8'($urandom_range(0, 255));
    run_check(1, 3, key, 1'b0, -1);

    // start held across a whole run, then relaunching straight out of DONE
    run_check(0, 2, 8'h00, 1'b1, -1);
    run_check(0, 0, 8'h00, 1'b0, -1);

    key = 8'($urandom_range(0, 255));
    run_check(0, 3, key, 1'b0, 100);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    check_idle_zero(0, "idle_after_abort");
    run_check(0, 3, key, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
